// File: rtl/mcm_rx_frame_coord.sv
// MCM answer-receive coordinator: arms on iRQ, synchronises iVal and issues one frame-RAM write per byte.
// Define MCM_COORD_BANK_EN for ping-pong banking (oAddr MSB selects the bank).
module mcm_rx_frame_coord #(
  parameter int FRAME_LEN   = 144,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES = 3,
  localparam int CNT_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iRQ,
  input  logic              iVal,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oWrEn,
  output logic [CNT_W-1:0]  oByteCnt,
  output logic              oBusy,
  output logic              oDone,
  output logic              oTimeout,
  output logic              oOverrun,
  output logic              oBank
);

  typedef enum logic [2:0] {IDLE, ARMED, RECV, DONE, TOUT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   rise;
  logic                   fall;
  logic                   inByte;
  logic                   active;
  logic                   tmoHit;
  logic                   lastCommit;
  logic [ADDR_W-1:0]      startAddr;
  logic [ADDR_W-1:0]      incAddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) syncQ <= '0;
    else        syncQ <= {syncQ[SYNC_STAGES-2:0], iVal};
  end

  assign rise       = syncQ[SYNC_STAGES-2] & ~syncQ[SYNC_STAGES-1];
  assign fall       = ~syncQ[SYNC_STAGES-2] & syncQ[SYNC_STAGES-1];
  assign active     = (state == ARMED) || (state == RECV);
  assign lastCommit = active && !iRQ && !tmoHit && fall && inByte &&
                      (oByteCnt == CNT_W'(FRAME_LEN - 1));

`ifdef MCM_COORD_BANK_EN
  localparam int OFS_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] RST_ADDR = {1'b0, OFS_W'(BASE_ADDR)};
  logic fillBank;

  // Offsets wrap inside the bank; the bank bit is only changed by a restart.
  assign startAddr = {fillBank, OFS_W'(BASE_ADDR)};
  assign incAddr   = {oAddr[ADDR_W-1], oAddr[OFS_W-1:0] + OFS_W'(1)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fillBank <= 1'b0;
      oBank    <= 1'b0;
    end else if (lastCommit) begin
      oBank    <= fillBank;
      fillBank <= ~fillBank;
    end
  end
`else
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(BASE_ADDR);
  assign startAddr = RST_ADDR;
  assign incAddr   = oAddr + ADDR_W'(1);
  assign oBank     = 1'b0;
`endif

  generate
    if (TIMEOUT_CYC > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      logic [TW-1:0] tmoCnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               tmoCnt <= '0;
        else if (iRQ || rise || fall || !active)  tmoCnt <= '0;
        else                                      tmoCnt <= tmoCnt + TW'(1);
      end

      assign tmoHit = active && !iRQ && !rise && !fall && (tmoCnt == TW'(TIMEOUT_CYC - 1));
    end else begin : g_noTmo
      assign tmoHit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      inByte   <= 1'b0;
      oAddr    <= RST_ADDR;
      oWrEn    <= 1'b0;
      oByteCnt <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oWrEn <= 1'b0;
      if (iRQ) begin
        // Restart wins over any edge seen in the same cycle.
        state    <= ARMED;
        inByte   <= 1'b0;
        oAddr    <= startAddr;
        oByteCnt <= '0;
        oBusy    <= 1'b1;
        oDone    <= 1'b0;
        oTimeout <= 1'b0;
        oOverrun <= 1'b0;
      end else begin
        // The write cycle itself presents the old address; advance afterwards.
        if (oWrEn) begin
          oAddr    <= incAddr;
          oByteCnt <= oByteCnt + CNT_W'(1);
          if (state == DONE) begin
            oDone <= 1'b1;
            oBusy <= 1'b0;
          end
        end
        if (rise)      inByte <= 1'b1;
        else if (fall) inByte <= 1'b0;
        case (state)
          ARMED, RECV: begin
            if (tmoHit) begin
              state    <= TOUT;
              oTimeout <= 1'b1;
              oBusy    <= 1'b0;
            end else if (rise) begin
              state <= RECV;
            end else if (fall && inByte) begin
              oWrEn <= 1'b1;
              if (lastCommit) state <= DONE;
            end
          end
          DONE:    if (rise) oOverrun <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
